mips_ifetch: RTL and testbench
==============================

# mips_ifetch

Instruction fetch unit for the MIPS datapath. It holds the PC, issues one read at a time to instruction memory, and presents the fetched word with its 6-bit opcode to the control decoder through a valid/ready handshake. It computes the next PC (sequential, beq-taken, or jump) from the held instruction and the decoder's Branch/Jump results.

## Interface
- RESET_PC, 32'h0000_3000, PC loaded on reset; bits [1:0] must be 0.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request, one-cycle pulse.
- imem_addr  out  32  read address; equals pc.
- imem_rvalid  in  1  read data valid; at least 1 cycle after imem_req.
- imem_rdata  in  32  instruction word; sampled when imem_rvalid=1.
- inst_valid  out  1  inst/op/inst_pc/pc_plus4 hold a valid instruction.
- inst_ready  in  1  consumer accepts the instruction this cycle.
- inst  out  32  held instruction word.
- op  out  6  inst[31:26], drives the control decoder.
- inst_pc  out  32  address of the held instruction.
- pc_plus4  out  32  inst_pc + 4, modulo 2^32.
- branch  in  1  decoder Branch for the held instruction.
- zero  in  1  ALU zero flag for the held instruction.
- jump  in  1  decoder Jump for the held instruction.
- inst_count  out  32  count of accepted instructions; wraps to 0.

## Operation
- FSM states: IDLE, FETCH, WAIT, HOLD. The reset state is IDLE.
- IDLE: moves unconditionally to FETCH on the next edge.
- FETCH: imem_req=1 and imem_addr=pc. Moves to WAIT unconditionally. The memory has no grant; the request is taken in this cycle.
- WAIT: imem_req=0. On imem_rvalid=1, the FSM loads inst from imem_rdata, sets inst_valid=1, and moves to HOLD. Otherwise it stays in WAIT with no timeout.
- HOLD: inst_valid=1. inst, op, inst_pc and pc_plus4 stay stable until accepted.
  - On inst_ready=1, the FSM updates pc to next_pc, increments inst_count, clears inst_valid, and moves to FETCH.
  - On inst_ready=0, the FSM stays in HOLD.
- next_pc selection, evaluated only in the HOLD & inst_ready cycle:
  - jump=1: {pc_plus4[31:28], inst[25:0], 2'b00}. Jump has priority over branch.
  - branch=1 and zero=1: pc_plus4 + {{14{inst[15]}}, inst[15:0], 2'b00}, modulo 2^32.
  - otherwise: pc_plus4.
- branch, zero and jump are ignored in every other state and cycle.
- imem_rvalid outside WAIT is ignored. A stale response after reset is dropped.
- Only one request is ever outstanding.
- inst_pc is pc while in HOLD. pc changes only on acceptance.

## Timing
- Reset values, applied asynchronously while rst_n=0:
  - pc=RESET_PC
  - imem_req=0, imem_addr=RESET_PC
  - inst_valid=0, inst=0, op=0
  - inst_pc=RESET_PC, pc_plus4=RESET_PC+4
  - inst_count=0
- First request: imem_req=1 in the 2nd cycle after rst_n rises. Cycle 1 is IDLE; cycle 2 is FETCH.
- Fetch latency with imem_rvalid one cycle after req:
  - req in cycle N
  - rvalid in cycle N+1
  - inst_valid=1 in cycle N+2
- Best-case throughput is one instruction per 3 cycles (FETCH, WAIT, HOLD with inst_ready=1). The next imem_req follows the accept cycle by exactly one edge.
- Reset asserted in any state takes effect immediately. Operation resumes with IDLE → FETCH at RESET_PC.
- inst_count increments on the accept edge and wraps 0xFFFF_FFFF → 0.
- PC wrap: the sequential successor of 0xFFFF_FFFC is 0x0000_0000.

## Test plan
- Reset, RESET_PC=0x3000:
  - During reset: all outputs at the listed reset values.
  - After release: imem_req=1 with imem_addr=0x3000 exactly 2 cycles later, and imem_req=0 in the following cycle.
- Sequential fetch: 0x2008_0005 returned with 1-cycle latency and inst_ready=1.
  - op=0x08, inst_pc=0x3000, pc_plus4=0x3004.
  - Next imem_addr=0x3004; inst_count=1.
- Branch: inst 0x1000_FFFF at 0x3004.
  - branch=1, zero=1 → next imem_addr=0x3004.
  - branch=1, zero=0 → next imem_addr=0x3008.
- Jump: inst 0x0800_0C10 at 0x3008 with jump=1 → next imem_addr=0x0000_3040. With branch=1 and zero=1 also set, the result is still 0x3040.
- Backpressure and slow memory:
  - rvalid 4 cycles after req → no imem_req in between; inst_valid rises 1 cycle after rvalid.
  - inst_ready=0 for 5 cycles → inst, inst_pc and inst_count stable, no imem_req.
  - A spurious rvalid during HOLD is ignored.
- Reset during WAIT, then a stale rvalid → inst_valid stays 0 and the first fetch is again at 0x3000.
- PC wrap: RESET_PC=0xFFFF_FFFC with one sequential accept → next imem_addr=0x0000_0000.

Source files
------------

// File: rtl/mips_ifetch_if.sv
// ---------------------------------------------------------------------------
// mips_ifetch_if
// Bundles the instruction-memory read port and the fetch-to-decoder
// handshake of the MIPS instruction fetch unit.
//
//   imem_req     fetch -> mem   one-cycle read request
//   imem_addr    fetch -> mem   read address (current pc)
//   imem_rvalid  mem -> fetch   read data valid
//   imem_rdata   mem -> fetch   instruction word
//   inst_valid   fetch -> dec   held instruction is valid
//   inst_ready   dec -> fetch   decoder accepts the instruction
//   inst         fetch -> dec   held instruction word
//   op           fetch -> dec   inst[31:26]
//   inst_pc      fetch -> dec   address of the held instruction
//   pc_plus4     fetch -> dec   inst_pc + 4
//   branch       dec -> fetch   Branch for the held instruction
//   zero         dec -> fetch   ALU zero flag for the held instruction
//   jump         dec -> fetch   Jump for the held instruction
//   inst_count   fetch -> dec   number of accepted instructions
//
// master: the fetch unit side; slave: memory/decoder side.
// ---------------------------------------------------------------------------
interface mips_ifetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [5:0]  op;
    logic [31:0] inst_pc;
    logic [31:0] pc_plus4;
    logic        branch;
    logic        zero;
    logic        jump;
    logic [31:0] inst_count;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata,
        output inst_valid,
        input  inst_ready,
        output inst,
        output op,
        output inst_pc,
        output pc_plus4,
        input  branch,
        input  zero,
        input  jump,
        output inst_count
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  op,
        input  inst_pc,
        input  pc_plus4,
        output branch,
        output zero,
        output jump,
        input  inst_count
    );
endinterface

// File: rtl/mips_ifetch.sv
// ---------------------------------------------------------------------------
// mips_ifetch
// Instruction fetch unit of the MIPS datapath. Holds the PC, issues one
// instruction-memory read at a time, presents the fetched word to the
// control decoder through a valid/ready handshake and selects the next PC
// (sequential, beq-taken or jump) when the decoder accepts the instruction.
//
// Ports:
//   clk    in   clock, all state updates on the rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    if   mips_ifetch_if.master (memory port + decoder handshake)
//
// Parameter:
//   RESET_PC   PC loaded on reset, word aligned
// ---------------------------------------------------------------------------
module mips_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic          clk,
    input  logic          rst_n,
    mips_ifetch_if.master bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] count_q, count_d;
    logic        valid_q, valid_d;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] next_pc;
    logic        accept;

    // The held instruction always lives at pc, so its successor and both
    // control-flow targets are derived directly from pc_q and inst_q.
    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], inst_q[25:0], 2'b00};
    assign accept        = (state_q == HOLD) && bus.inst_ready;

    // Next-PC mux: jump wins over a taken branch. Only consumed on accept,
    // so branch/zero/jump have no effect in any other cycle.
    always_comb begin
        next_pc = pc_plus4;
        if (bus.jump) begin
            next_pc = jump_target;
        end else if (bus.branch && bus.zero) begin
            next_pc = branch_target;
        end
    end

    // Fetch sequencing: IDLE -> FETCH -> WAIT (until rvalid) -> HOLD (until
    // accepted) -> FETCH. rvalid is only looked at in WAIT, which both keeps
    // a single request outstanding and drops responses that arrive in any
    // other state, e.g. a stale one from before a reset.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        count_d = count_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    inst_d  = bus.imem_rdata;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    pc_d    = next_pc;
                    count_d = count_q + 32'd1;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. The instruction word is kept after acceptance; only
    // inst_valid qualifies it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= 32'd0;
            count_q <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // All outputs are decoded from registered state only, so they are
    // stable for the whole cycle and free of input-to-output paths.
    assign bus.imem_req   = (state_q == FETCH);
    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = valid_q;
    assign bus.inst       = inst_q;
    assign bus.op         = inst_q[31:26];
    assign bus.inst_pc    = pc_q;
    assign bus.pc_plus4   = pc_plus4;
    assign bus.inst_count = count_q;

endmodule

// File: tb/tb_mips_ifetch.sv
// ---------------------------------------------------------------------------
// tb_mips_ifetch
// Self-checking bench for mips_ifetch. Two instances share clock, reset and
// stimulus: dutA uses the default reset PC, dutB starts at 0xFFFF_FFFC to
// exercise PC wrap. 'sel' routes handshake inputs to one instance and
// selects whose outputs are observed.
// ---------------------------------------------------------------------------
module tb_mips_ifetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        br, zr, jp;

    mips_ifetch_if ifA ();
    mips_ifetch_if ifB ();

    assign ifA.imem_rvalid = rvalid & ~sel;
    assign ifA.imem_rdata  = rdata;
    assign ifA.inst_ready  = ready & ~sel;
    assign ifA.branch      = br;
    assign ifA.zero        = zr;
    assign ifA.jump        = jp;

    assign ifB.imem_rvalid = rvalid & sel;
    assign ifB.imem_rdata  = rdata;
    assign ifB.inst_ready  = ready & sel;
    assign ifB.branch      = br;
    assign ifB.zero        = zr;
    assign ifB.jump        = jp;

    mips_ifetch #(.RESET_PC(32'h0000_3000)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifA)
    );

    mips_ifetch #(.RESET_PC(32'hFFFF_FFFC)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifB)
    );

    logic        req, valid;
    logic [31:0] addr, instO, instPc, pcPlus4, count;
    logic [5:0]  op;

    assign req     = sel ? ifB.imem_req   : ifA.imem_req;
    assign valid   = sel ? ifB.inst_valid : ifA.inst_valid;
    assign addr    = sel ? ifB.imem_addr  : ifA.imem_addr;
    assign instO   = sel ? ifB.inst       : ifA.inst;
    assign instPc  = sel ? ifB.inst_pc    : ifA.inst_pc;
    assign pcPlus4 = sel ? ifB.pc_plus4   : ifA.pc_plus4;
    assign count   = sel ? ifB.inst_count : ifA.inst_count;
    assign op      = sel ? ifB.op         : ifA.op;

    int nChecks = 0;
    int nPass   = 0;

    // Reference model state: where the next fetch must go and how many
    // instructions have been accepted so far.
    logic [31:0] expPc;
    logic [31:0] expCount;

    typedef struct {
        logic [31:0] inst;
        logic        b;
        logic        z;
        logic        j;
        logic [31:0] pc;
        logic [31:0] expNext;
        logic [5:0]  expOp;
    } vec_t;

    vec_t vecs [5];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Next PC from the architectural rules: jump region concatenation,
    // signed word offset for a taken beq, else the following word.
    function automatic logic [31:0] modelNextPc(input logic [31:0] pc, input logic [31:0] instW,
                                                input logic b, input logic z, input logic j);
        logic [31:0] seq;
        int          off;
        seq = pc + 32'd4;
        off = int'($signed(instW[15:0]));
        if (j) return (seq & 32'hF000_0000) | ((instW & 32'h03FF_FFFF) << 2);
        if (b && z) return seq + 32'(off * 4);
        return seq;
    endfunction

    // Expected view of a FETCH cycle.
    task automatic checkFetch();
        checkOutput("fetch req", {31'd0, req}, 32'd1);
        checkOutput("fetch addr", addr, expPc);
        checkOutput("fetch valid", {31'd0, valid}, 32'd0);
        checkOutput("fetch count", count, expCount);
    endtask

    // Reset the selected instance, check the asynchronous reset values and
    // the IDLE cycle; returns at the falling edge inside the first FETCH.
    task automatic doReset(input logic selIn);
        logic [31:0] rpc;
        rpc    = selIn ? 32'hFFFF_FFFC : 32'h0000_3000;
        @(negedge clk);
        sel    = selIn;
        rvalid = 1'b0;
        ready  = 1'b0;
        rst_n  = 1'b0;
        #1;
        checkOutput("rst req", {31'd0, req}, 32'd0);
        checkOutput("rst addr", addr, rpc);
        checkOutput("rst valid", {31'd0, valid}, 32'd0);
        checkOutput("rst inst", instO, 32'd0);
        checkOutput("rst op", {26'd0, op}, 32'd0);
        checkOutput("rst inst_pc", instPc, rpc);
        checkOutput("rst pc_plus4", pcPlus4, rpc + 32'd4);
        checkOutput("rst count", count, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle req", {31'd0, req}, 32'd0);
        @(negedge clk);
        expPc    = rpc;
        expCount = 32'd0;
    endtask

    // One complete fetch transaction starting at the falling edge of a
    // FETCH cycle: response 'lat' cycles after the request, 'holdCycles'
    // cycles of backpressure (optionally with spurious rvalid), then accept
    // with the given control bits. Ends at the falling edge of the next FETCH.
    task automatic applyStimulus(input logic [31:0] instW, input int lat, input int holdCycles,
                                 input bit spurious, input logic b, input logic z, input logic j,
                                 output logic [5:0] opSeen);
        logic [31:0] nxt;
        checkFetch();
        for (int k = 1; k <= lat; k++) begin
            br = 1'($urandom);
            zr = 1'($urandom);
            jp = 1'($urandom);
            @(negedge clk);
            checkOutput("wait req", {31'd0, req}, 32'd0);
            checkOutput("wait valid", {31'd0, valid}, 32'd0);
        end
        rvalid = 1'b1;
        rdata  = instW;
        @(negedge clk);
        rvalid = 1'b0;
        rdata  = $urandom;
        opSeen = op;
        checkOutput("hold valid", {31'd0, valid}, 32'd1);
        checkOutput("hold inst", instO, instW);
        checkOutput("hold op", {26'd0, op}, instW >> 26);
        checkOutput("hold inst_pc", instPc, expPc);
        checkOutput("hold pc_plus4", pcPlus4, expPc + 32'd4);
        checkOutput("hold req", {31'd0, req}, 32'd0);
        for (int k = 0; k < holdCycles; k++) begin
            ready = 1'b0;
            br    = 1'($urandom);
            zr    = 1'($urandom);
            jp    = 1'($urandom);
            if (spurious) begin
                rvalid = 1'b1;
                rdata  = $urandom;
            end
            @(negedge clk);
            rvalid = 1'b0;
            checkOutput("stall valid", {31'd0, valid}, 32'd1);
            checkOutput("stall inst", instO, instW);
            checkOutput("stall inst_pc", instPc, expPc);
            checkOutput("stall count", count, expCount);
            checkOutput("stall req", {31'd0, req}, 32'd0);
        end
        ready = 1'b1;
        br    = b;
        zr    = z;
        jp    = j;
        nxt   = modelNextPc(expPc, instW, b, z, j);
        @(negedge clk);
        ready    = 1'b0;
        br       = 1'($urandom);
        zr       = 1'($urandom);
        jp       = 1'($urandom);
        expPc    = nxt;
        expCount = expCount + 32'd1;
    endtask

    initial begin
        logic [5:0] opSeen;
        rst_n  = 1'b0;
        sel    = 1'b0;
        rvalid = 1'b0;
        rdata  = 32'd0;
        ready  = 1'b0;
        br     = 1'b0;
        zr     = 1'b0;
        jp     = 1'b0;

        vecs[0] = '{32'h2008_0005, 1'b0, 1'b0, 1'b0, 32'h0000_3000, 32'h0000_3004, 6'h08};
        vecs[1] = '{32'h1000_FFFF, 1'b1, 1'b1, 1'b0, 32'h0000_3004, 32'h0000_3004, 6'h04};
        vecs[2] = '{32'h1000_FFFF, 1'b1, 1'b0, 1'b0, 32'h0000_3004, 32'h0000_3008, 6'h04};
        vecs[3] = '{32'h0800_0C10, 1'b0, 1'b0, 1'b1, 32'h0000_3008, 32'h0000_3040, 6'h02};
        vecs[4] = '{32'h0800_0C10, 1'b1, 1'b1, 1'b1, 32'h0000_3040, 32'h0000_3040, 6'h02};

        doReset(1'b0);

        // Directed vectors: sequential, beq taken/not taken, jump, jump over branch.
        for (int i = 0; i < 5; i++) begin
            checkOutput("vec pc", addr, vecs[i].pc);
            applyStimulus(vecs[i].inst, 1, 0, 1'b0, vecs[i].b, vecs[i].z, vecs[i].j, opSeen);
            checkOutput("vec op", {26'd0, opSeen}, {26'd0, vecs[i].expOp});
            checkOutput("vec next", addr, vecs[i].expNext);
        end
        checkOutput("vec count", count, 32'd5);

        // Slow memory plus five cycles of backpressure with spurious rvalid.
        applyStimulus(32'h0000_0020, 4, 5, 1'b1, 1'b0, 1'b0, 1'b0, opSeen);

        // Randomized transactions against the model.
        for (int i = 0; i < 40; i++) begin
            applyStimulus($urandom, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), opSeen);
        end
        checkFetch();

        // Reset during WAIT with a stale response still on the bus.
        @(negedge clk);
        rvalid = 1'b1;
        rdata  = 32'hDEAD_BEEF;
        rst_n  = 1'b0;
        #1;
        checkOutput("wrst valid", {31'd0, valid}, 32'd0);
        checkOutput("wrst addr", addr, 32'h0000_3000);
        checkOutput("wrst count", count, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("wrst idle req", {31'd0, req}, 32'd0);
        checkOutput("wrst idle valid", {31'd0, valid}, 32'd0);
        @(negedge clk);
        rvalid   = 1'b0;
        expPc    = 32'h0000_3000;
        expCount = 32'd0;
        applyStimulus(32'h2008_0005, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, opSeen);
        checkFetch();

        // PC wrap on the instance that starts at the top of the address space.
        doReset(1'b1);
        applyStimulus(32'h0000_0000, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, opSeen);
        checkOutput("wrap addr", addr, 32'h0000_0000);
        checkFetch();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
